// File: rtl/mem_port_arbiter.sv
// Arbiter for one single-ported, pipelined memory shared between instruction
// fetch and the data stage. Data wins by default. Fetch is forced through after
// STARVE_LIMIT consecutive data grants. Read responses return to their issuer
// in order, using a small owner FIFO.
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    // fetch side
    input  logic        ireq_i,
    input  logic [31:0] iaddr_i,
    output logic        igrant_o,
    output logic        irvalid_o,
    output logic [31:0] irdata_o,
    // data side
    input  logic        dreq_i,
    input  logic        dwe_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    input  logic [3:0]  dbe_i,
    output logic        dgrant_o,
    output logic        drvalid_o,
    output logic [31:0] drdata_o,
    // shared memory port
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CntW-1:0] MaxCnt    = CntW'(MAX_OUTSTANDING);
    localparam logic [PtrW-1:0] LastPtr   = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT);

    logic [CntW-1:0]            r_count;
    logic [PtrW-1:0]            r_wptr;
    logic [PtrW-1:0]            r_rptr;
    logic [MAX_OUTSTANDING-1:0] r_owner;   // 0 = fetch, 1 = data
    logic [StW-1:0]             r_starve;
    logic                       r_err;

    logic w_full;
    logic w_i_ok;
    logic w_d_ok;
    logic w_sel_i;
    logic w_sel_d;
    logic w_acc;
    logic w_push;
    logic w_pop;
    logic w_head;

    // Request selection; a full owner FIFO blocks reads from either side, never writes.
    always_comb begin
        w_full  = (r_count == MaxCnt);
        w_i_ok  = ireq_i & ~w_full;
        w_d_ok  = dreq_i & (dwe_i | ~w_full);
        w_sel_i = w_i_ok & (~dreq_i | (r_starve == StarveMax));
        w_sel_d = w_d_ok & ~w_sel_i;
    end

    // Memory port mux and grants; all fields idle at zero when nothing is selected.
    always_comb begin
        mem_req_o   = w_sel_i | w_sel_d;
        mem_we_o    = w_sel_d & dwe_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (w_sel_d) begin
            mem_addr_o  = daddr_i;
            mem_wdata_o = dwe_i ? dwdata_i : '0;
            mem_be_o    = dwe_i ? dbe_i : 4'hF;
        end else if (w_sel_i) begin
            mem_addr_o  = iaddr_i;
            mem_be_o    = 4'hF;
        end
        igrant_o = w_sel_i & mem_gnt_i;
        dgrant_o = w_sel_d & mem_gnt_i;
    end

    // Response routing: the FIFO head picks the destination in the same cycle.
    always_comb begin
        w_acc     = mem_req_o & mem_gnt_i;
        w_push    = w_acc & ~mem_we_o;
        w_pop     = mem_rvalid_i & (r_count != '0);
        w_head    = r_owner[r_rptr];
        irvalid_o = w_pop & ~w_head;
        drvalid_o = w_pop & w_head;
        irdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
        drdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
        err_o     = r_err;
    end

    // Owner FIFO, outstanding count and sticky error flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_owner <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_owner[r_wptr] <= w_sel_d;
                r_wptr          <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (mem_rvalid_i && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Starvation guard: counts data grants taken while fetch is waiting.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_starve <= '0;
        end else if (!ireq_i || igrant_o) begin
            r_starve <= '0;
        end else if (dgrant_o && (r_starve != StarveMax)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, pipelined memory between the fetch stage (instruction reads) and the memory stage (data reads and writes).
- Arbitrates requests and grants the data side by default, with a starvation guard for fetch.
- Tracks outstanding reads in order and routes each read response back to the requester that issued it.
- Sits between the core's imem/dmem interfaces and the shared memory port in the core wrapper.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered reads; power of two, 1..8.
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch waits before fetch is forced to win one cycle.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- ireq_i  in  1  fetch read request
- iaddr_i  in  32  fetch address
- igrant_o  out  1  fetch request accepted this cycle
- irvalid_o  out  1  fetch read data valid
- irdata_o  out  32  fetch read data
- dreq_i  in  1  data request
- dwe_i  in  1  1 = write, 0 = read
- daddr_i  in  32  data address
- dwdata_i  in  32  write data
- dbe_i  in  4  write byte enables
- dgrant_o  out  1  data request accepted this cycle
- drvalid_o  out  1  data read data valid
- drdata_o  out  32  data read data
- mem_req_o  out  1  request to memory
- mem_we_o  out  1  write strobe
- mem_addr_o  out  32  address
- mem_wdata_o  out  32  write data
- mem_be_o  out  4  byte enables; 4'hF on reads
- mem_gnt_i  in  1  memory accepts the request this cycle
- mem_rvalid_i  in  1  read response valid; one per accepted read, in order
- mem_rdata_i  in  32  read response data
- err_o  out  1  sticky: response with no outstanding read

Behaviour:
- Reset: outstanding count 0, owner FIFO pointers 0, starve counter 0, err_o 0.
  - All combinational outputs are 0 whenever there are no requests and no responses.
- Clock and reset: one clock (clk_i); reset is asynchronous and active-low (rstn_i).
- Selection (combinational, per cycle):
  - Default: data wins when dreq_i=1.
  - Fetch wins if only ireq_i=1.
  - Fetch also wins if ireq_i=1 and the starve counter equals STARVE_LIMIT.
- Read blocking: a read is not selectable when the registered outstanding count equals MAX_OUTSTANDING.
  - A same-cycle mem_rvalid_i does not free a slot that cycle.
  - Writes are never blocked by the count.
  - If data is blocked (read, full), fetch is also blocked (read), so mem_req_o=0.
- mem_req_o is 1 iff a request is selected. mem_* fields are muxed from the selected requester.
- Grants: the selected requester's grant = mem_gnt_i; the other requester's grant = 0.
  - Requesters hold request and fields stable until granted.
- Accepted transfer = mem_req_o & mem_gnt_i. On an accepted read, push an owner bit (0 fetch, 1 data) into the owner FIFO.
- Response routing:
  - mem_rvalid_i with count > 0: pop the FIFO head. The head bit selects irvalid_o or drvalid_o, same cycle (zero latency); rdata is passed through to both data outputs.
  - mem_rvalid_i with count = 0: no valid raised, err_o set until reset.
- Count update: count += accepted read − valid pop. Simultaneous push and pop leaves the count unchanged; pointers wrap modulo MAX_OUTSTANDING.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each accepted data transfer while ireq_i=1.
  - Clears on an accepted fetch transfer or when ireq_i=0.
- Reset mid-operation: all state clears. Responses to pre-reset reads arriving after reset set err_o; the integration must not do this.
- Latency: grant in the request cycle when mem_gnt_i=1; response latency is set by the memory.

Test Plan:
- Fetch only: ireq_i=1, iaddr_i=0x100, mem_gnt_i=1, memory answers 0xDEADBEEF next cycle → mem_addr_o=0x100, igrant_o=1, then irvalid_o=1 with irdata_o=0xDEADBEEF, drvalid_o=0.
- Contention: both request, dreq read 0x2000, mem_gnt_i=1 → dgrant_o=1, igrant_o=0. Responses return in order: first to data, second to fetch after fetch is granted.
- Starvation: dreq_i held with writes, ireq_i held, STARVE_LIMIT=4 → 4 data grants, fetch granted on the 5th cycle, then data resumes.
- Full: MAX_OUTSTANDING=2, two reads accepted with no response → third read sees mem_req_o=0. A write is still granted. After one mem_rvalid_i, the read is granted the next cycle.
- Simultaneous push and pop at count 1 → count stays 1. Owner order is preserved across pointer wrap over 10 mixed reads.
- Spurious response: mem_rvalid_i=1 with count 0 → no valid outputs, err_o=1 and held until rstn_i=0.
